// File: rtl/instruction_packer.sv
// Narrows signed 16-bit words into {opcode, 11-bit operand} instructions and writes them to sequential program-memory addresses.
// Optional macro INSTRUCTION_PACKER_SATURATE_EN clamps out-of-range words instead of dropping them.
module instruction_packer #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_opcode,
    input  logic [15:0]           in_data,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  done,
    output logic                  full,
    output logic                  range_err,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t      state;
    logic        last_q;
    logic        fits_q;
    logic        in_fits;
    logic        write_ok;
    logic [10:0] operand;

    // The word fits 11 signed bits only when the top six bits are pure sign extension.
    assign in_fits = (in_data[15:10] == {6{in_data[15]}});

`ifdef INSTRUCTION_PACKER_SATURATE_EN
    assign operand  = in_fits ? in_data[10:0] : (in_data[15] ? 11'h400 : 11'h3FF);
    assign write_ok = 1'b1;
`else
    assign operand  = in_data[10:0];
    assign write_ok = in_fits;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            full       <= 1'b0;
            range_err  <= 1'b0;
            word_count <= '0;
            last_q     <= 1'b0;
            fits_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCEPT;
                        in_ready   <= 1'b1;
                        mem_addr   <= '0;
                        word_count <= '0;
                        full       <= 1'b0;
                        range_err  <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        state     <= WRITE;
                        in_ready  <= 1'b0;
                        mem_we    <= write_ok;
                        mem_wdata <= {in_opcode, operand};
                        last_q    <= in_last;
                        fits_q    <= in_fits;
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    if (!fits_q) range_err <= 1'b1;
                    // The address parks at the top slot; full ends the session before it could wrap.
                    if (mem_we) begin
                        word_count <= word_count + 1'b1;
                        if (mem_addr == LAST_ADDR) full <= 1'b1;
                        else                       mem_addr <= mem_addr + 1'b1;
                    end
                    if (last_q || (mem_we && mem_addr == LAST_ADDR)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= ACCEPT;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_packer.sv
// Self-checking bench for instruction_packer: a default-size instance plus a 4-deep instance for the full case,
// with expected instructions computed from signed-range arithmetic.
module tb_instruction_packer;

`ifdef INSTRUCTION_PACKER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic        in_valid;
    logic [4:0]  in_opcode;
    logic [15:0] in_data;
    logic        in_last;

    logic        in_ready_a, mem_we_a, done_a, full_a, range_err_a;
    logic [10:0] mem_addr_a;
    logic [15:0] mem_wdata_a;
    logic [11:0] word_count_a;

    logic        in_ready_b, mem_we_b, done_b, full_b, range_err_b;
    logic [1:0]  mem_addr_b;
    logic [15:0] mem_wdata_b;
    logic [2:0]  word_count_b;

    logic        sel;
    logic        cur_ready, cur_we, cur_done, cur_full, cur_err;
    logic [10:0] cur_addr;
    logic [15:0] cur_wdata;
    logic [11:0] cur_count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    instruction_packer #(.ADDR_WIDTH(11)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_opcode(in_opcode), .in_data(in_data), .in_last(in_last), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .done(done_a), .full(full_a),
        .range_err(range_err_a), .word_count(word_count_a)
    );

    instruction_packer #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_opcode(in_opcode), .in_data(in_data), .in_last(in_last), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .done(done_b), .full(full_b),
        .range_err(range_err_b), .word_count(word_count_b)
    );

    assign cur_ready = sel ? in_ready_b  : in_ready_a;
    assign cur_we    = sel ? mem_we_b    : mem_we_a;
    assign cur_done  = sel ? done_b      : done_a;
    assign cur_full  = sel ? full_b      : full_a;
    assign cur_err   = sel ? range_err_b : range_err_a;
    assign cur_addr  = sel ? {9'b0, mem_addr_b}   : mem_addr_a;
    assign cur_wdata = sel ? mem_wdata_b          : mem_wdata_a;
    assign cur_count = sel ? {9'b0, word_count_b} : word_count_a;

    function automatic bit model_fits(input logic [15:0] d);
        int v;
        v = int'($signed(d));
        return (v >= -1024) && (v <= 1023);
    endfunction

    function automatic logic [15:0] model_instr(input logic [4:0] op, input logic [15:0] d);
        int v;
        logic [10:0] o;
        v = int'($signed(d));
        if (model_fits(d)) o = d[10:0];
        else if (v < 0)    o = 11'h400;
        else               o = 11'h3FF;
        return {op, o};
    endfunction

    function automatic logic [15:0] rand_data();
        logic [15:0] pool [6];
        int k;
        pool[0] = 16'h03FF; pool[1] = 16'hFC00; pool[2] = 16'h0400;
        pool[3] = 16'hFBFF; pool[4] = 16'h8000; pool[5] = 16'h7FFF;
        k = $urandom_range(0, 9);
        if (k < 5)      return 16'(int'($urandom_range(0, 2047)) - 1024);
        else if (k < 7) return 16'($urandom);
        else            return pool[$urandom_range(0, 5)];
    endfunction

    task automatic start_session(input bit which, output logic rdy);
        @(negedge clk);
        sel = which;
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        rdy = cur_ready;
    endtask

    task automatic drive_word(input logic [4:0] op, input logic [15:0] d, input bit last, input bit hold,
                              output bit ok, output logic we, output logic [10:0] addr,
                              output logic [15:0] wd, output logic rdy);
        in_valid  = 1'b1;
        in_opcode = op;
        in_data   = d;
        in_last   = last;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cur_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
        end
        if (ok) begin
            @(negedge clk);
            we = cur_we; addr = cur_addr; wd = cur_wdata; rdy = cur_ready;
        end else begin
            we = 1'b0; addr = '0; wd = '0; rdy = 1'b0;
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready_a, mem_we_a, done_a, full_a, range_err_a, mem_addr_a, mem_wdata_a, word_count_a} !== '0 ||
            {in_ready_b, mem_we_b, done_b, full_b, range_err_b, mem_addr_b, mem_wdata_b, word_count_b} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: a=%h_%h_%h b=%h_%h_%h required all zero",
                     mem_addr_a, mem_wdata_a, word_count_a, mem_addr_b, mem_wdata_b, word_count_b);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [4:0]  ops [3];
        logic [15:0] dat [3];
        logic [15:0] exp_w [3];
        bit ok; logic we, rdy; logic [10:0] addr; logic [15:0] wd;
        ops[0] = 5'b00011; dat[0] = 16'h0005; exp_w[0] = 16'h1805;
        ops[1] = 5'b00100; dat[1] = 16'hFC00; exp_w[1] = 16'h2400;
        ops[2] = 5'b00001; dat[2] = 16'h03FF; exp_w[2] = 16'h0BFF;
        start_session(1'b0, rdy);
        vectors++;
        if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL basic_start_ready: got %b want 1", rdy); end
        for (int i = 0; i < 3; i++) begin
            drive_word(ops[i], dat[i], i == 2, 1'b0, ok, we, addr, wd, rdy);
            vectors++;
            if (!ok || we !== 1'b1 || addr !== 11'(i) || wd !== exp_w[i] || rdy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_write%0d: ok=%b we=%b addr=%0d data=%h ready=%b want we=1 addr=%0d data=%h ready=0",
                         i, ok, we, addr, wd, rdy, i, exp_w[i]);
            end
        end
        @(negedge clk);
        vectors++;
        if (cur_done !== 1'b1 || cur_count !== 12'd3 || cur_err !== 1'b0 || cur_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done: done=%b count=%0d err=%b full=%b want 1/3/0/0", cur_done, cur_count, cur_err, cur_full);
        end
        @(negedge clk);
        vectors++;
        if (cur_done !== 1'b0 || cur_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_done_pulse: done=%b ready=%b want 0/0", cur_done, cur_ready);
        end
    endtask

    task automatic test_overflow();
        logic [4:0]  ops [2];
        logic [15:0] dat [2];
        logic [15:0] exp_w [2];
        bit ok; logic we, rdy; logic [10:0] addr; logic [15:0] wd;
        ops[0] = 5'b00010; dat[0] = 16'h0400; exp_w[0] = 16'h13FF;
        ops[1] = 5'b00101; dat[1] = 16'h8000; exp_w[1] = 16'h2C00;
        for (int i = 0; i < 2; i++) begin
            start_session(1'b0, rdy);
            drive_word(ops[i], dat[i], 1'b1, 1'b0, ok, we, addr, wd, rdy);
            vectors++;
            if (!ok || we !== SAT || (SAT && (wd !== exp_w[i] || addr !== 11'd0))) begin
                errors++;
                $display("[TB] FAIL overflow%0d_write: ok=%b we=%b addr=%0d data=%h want we=%b data=%h",
                         i, ok, we, addr, wd, SAT, exp_w[i]);
            end
            @(negedge clk);
            vectors++;
            if (cur_done !== 1'b1 || cur_err !== 1'b1 || cur_count !== 12'(SAT)) begin
                errors++;
                $display("[TB] FAIL overflow%0d_end: done=%b err=%b count=%0d want 1/1/%0d", i, cur_done, cur_err, cur_count, SAT);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full();
        bit ok; logic we, rdy; logic [10:0] addr; logic [15:0] wd;
        logic [4:0] op; logic [15:0] d;
        start_session(1'b1, rdy);
        for (int i = 0; i < 4; i++) begin
            op = 5'($urandom);
            d  = 16'(int'($urandom_range(0, 2047)) - 1024);
            drive_word(op, d, 1'b0, 1'b0, ok, we, addr, wd, rdy);
            vectors++;
            if (!ok || we !== 1'b1 || addr !== 11'(i) || wd !== model_instr(op, d)) begin
                errors++;
                $display("[TB] FAIL full_write%0d: ok=%b we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                         i, ok, we, addr, wd, i, model_instr(op, d));
            end
        end
        @(negedge clk);
        vectors++;
        if (cur_done !== 1'b1 || cur_full !== 1'b1 || cur_count !== 12'd4 || cur_ready !== 1'b0 || cur_addr !== 11'd3) begin
            errors++;
            $display("[TB] FAIL full_end: done=%b full=%b count=%0d ready=%b addr=%0d want 1/1/4/0/3",
                     cur_done, cur_full, cur_count, cur_ready, cur_addr);
        end
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok; logic we, rdy; logic [10:0] addr; logic [15:0] wd;
        start_session(1'b0, rdy);
        drive_word(5'b01010, 16'h0123, 1'b0, 1'b0, ok, we, addr, wd, rdy);
        vectors++;
        if (!ok || we !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_write: ok=%b we=%b want 1/1", ok, we); end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready_a, mem_we_a, done_a, full_a, range_err_a, mem_addr_a, mem_wdata_a, word_count_a} !== '0) begin
            errors++;
            $display("[TB] FAIL rstmid_clear: ready=%b we=%b addr=%0d data=%h count=%0d want all zero",
                     in_ready_a, mem_we_a, mem_addr_a, mem_wdata_a, word_count_a);
        end
        reset = 1'b1;
        start_session(1'b0, rdy);
        drive_word(5'b00111, 16'hFFFF, 1'b1, 1'b0, ok, we, addr, wd, rdy);
        vectors++;
        if (!ok || we !== 1'b1 || addr !== 11'd0 || wd !== model_instr(5'b00111, 16'hFFFF)) begin
            errors++;
            $display("[TB] FAIL rstmid_restart: ok=%b we=%b addr=%0d data=%h want we=1 addr=0 data=%h",
                     ok, we, addr, wd, model_instr(5'b00111, 16'hFFFF));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok; logic we, rdy; logic [10:0] addr; logic [15:0] wd;
        logic [4:0] op; logic [15:0] d;
        start_session(1'b0, rdy);
        for (int i = 0; i < 5; i++) begin
            op = 5'($urandom);
            d  = 16'(int'($urandom_range(0, 2047)) - 1024);
            if (i > 0) start_a = 1'b1;
            drive_word(op, d, i == 4, i != 4, ok, we, addr, wd, rdy);
            vectors++;
            if (!ok || we !== 1'b1 || addr !== 11'(i) || wd !== model_instr(op, d) || rdy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_write%0d: ok=%b we=%b addr=%0d data=%h ready=%b want we=1 addr=%0d data=%h ready=0",
                         i, ok, we, addr, wd, rdy, i, model_instr(op, d));
            end
        end
        @(negedge clk);
        vectors++;
        if (cur_done !== 1'b1 || cur_count !== 12'd5) begin
            errors++; $display("[TB] FAIL hold_end: done=%b count=%0d want 1/5", cur_done, cur_count);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit ok; logic we, rdy; logic [10:0] addr; logic [15:0] wd;
        logic [4:0] op; logic [15:0] d;
        int n, exp_addr; bit exp_err, exp_we;
        for (int s = 0; s < 6; s++) begin
            start_session(1'b0, rdy);
            n = $urandom_range(3, 8);
            exp_addr = 0;
            exp_err  = 1'b0;
            for (int i = 0; i < n; i++) begin
                op = 5'($urandom);
                d  = rand_data();
                exp_we = model_fits(d) || SAT;
                drive_word(op, d, i == n - 1, 1'b0, ok, we, addr, wd, rdy);
                vectors++;
                if (!ok || we !== exp_we || (exp_we && (addr !== 11'(exp_addr) || wd !== model_instr(op, d)))) begin
                    errors++;
                    $display("[TB] FAIL rand_s%0d_w%0d: in=%h ok=%b we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                             s, i, d, ok, we, addr, wd, exp_we, exp_addr, model_instr(op, d));
                end
                if (exp_we) exp_addr++;
                if (!model_fits(d)) exp_err = 1'b1;
            end
            @(negedge clk);
            vectors++;
            if (cur_done !== 1'b1 || cur_count !== 12'(exp_addr) || cur_err !== exp_err || cur_full !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand_s%0d_end: done=%b count=%0d err=%b full=%b want 1/%0d/%b/0",
                         s, cur_done, cur_count, cur_err, cur_full, exp_addr, exp_err);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        in_valid = 1'b0; in_opcode = '0; in_data = '0; in_last = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/instruction_packer.md
# instruction_packer

Program-memory writer for the BIP datapath: the narrowing counterpart of `signal_extension`. It accepts 16-bit signed data words with a 5-bit opcode over a valid/ready handshake and range-checks each word against the signed 11-bit operand field. It narrows the word to 11 bits, packs `{opcode, operand}` into a 16-bit instruction, and writes it to sequential program-memory addresses. It sits between the host loader (UART byte assembler) and the instruction memory write port.

## Interface
- `ADDR_WIDTH`, default 11: program memory address width; depth is 2^ADDR_WIDTH words.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load session; ignored unless in IDLE.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept a word.
- `in_opcode`  in  5  opcode for the word.
- `in_data`  in  16  signed operand value.
- `in_last`  in  1  marks the final word of the session.
- `mem_we`  out  1  program memory write enable.
- `mem_addr`  out  ADDR_WIDTH  write address.
- `mem_wdata`  out  16  packed instruction, `{opcode[4:0], operand[10:0]}`.
- `done`  out  1  one-cycle pulse at session end.
- `full`  out  1  sticky; session ended because memory is full.
- `range_err`  out  1  sticky; at least one word was out of range this session.
- `word_count`  out  ADDR_WIDTH+1  number of words written this session.

## Operation
- FSM states are IDLE, ACCEPT, WRITE and DONE. The state is registered.
- **IDLE:** `in_ready`=0.
  - On `start`, move to ACCEPT.
  - On the same edge, clear the address, `word_count`, `full` and `range_err`.
- **ACCEPT:** `in_ready`=1. On `in_valid & in_ready`:
  - Register the opcode, the narrowed operand, `in_last`, and an in-range flag.
  - Move to WRITE.
- **Range check:** a word fits if and only if `in_data[15:10]` are all equal. The narrowed operand is `in_data[10:0]`.
- **WRITE:** if the word is in range (or saturated, see Configuration):
  - `mem_we`=1 for this one cycle, with `mem_addr` and `mem_wdata` stable.
  - The address increments and `word_count` increments.
  - Out of range without saturation: `mem_we`=0, the word is dropped, and `range_err` is set.
- **WRITE next state:**
  - If the captured `in_last` is set, go to DONE.
  - If a write occurred at address 2^ADDR_WIDTH−1, set `full` and go to DONE.
  - Otherwise go back to ACCEPT.
  - A dropped word flagged `in_last` still ends the session.
- **DONE:** `done`=1 for one cycle, then IDLE.
- The address never wraps; `full` ends the session before any wrap.
- `start` while not in IDLE is ignored.
- `in_valid` with `in_ready`=0 is not consumed. The source must hold its word.
- **Reset values:** state IDLE; `in_ready`, `mem_we`, `done`, `full`, `range_err` all 0; `mem_addr`, `mem_wdata`, `word_count` all 0.
- Reset asserted mid-session abandons the session. If the reset edge falls in WRITE, `mem_we` is 0 from the next cycle and no write completes.

## Timing
- `in_ready` is decoded from the state register only. There is no combinational path from `in_valid`.
- If a handshake occurs at edge k, `mem_we`/`mem_addr`/`mem_wdata` are valid in cycle k+1 (edge k to k+1).
- Throughput is one word per 2 cycles. `in_ready` is low during WRITE.
- `done` is high in the cycle after the final WRITE cycle.
- `word_count` and `full` update on the edge that ends WRITE.
- `start` at edge s gives `in_ready`=1 from edge s onward.

## Configuration
- Macro: `INSTRUCTION_PACKER_SATURATE_EN`.
- **Defined:** out-of-range words are clamped and written.
  - `in_data[15]`=0 gives operand 11'h3FF.
  - `in_data[15]`=1 gives operand 11'h400.
  - `range_err` is still set.
- **Undefined:** out-of-range words are dropped (no `mem_we`, no address or count increment), and `range_err` is set.

## Test plan
- **Basic session:** `start`, then three words: (5'b00011, 16'h0005), (5'b00100, 16'hFC00), (5'b00001, 16'h03FF, `in_last`).
  - Writes 16'h1805@0, 16'h2400@1, 16'h0BFF@2.
  - `done` pulses once, `word_count`=3, `range_err`=0.
- **Positive overflow:** (5'b00010, 16'h0400).
  - Without the macro: no `mem_we`, `word_count` unchanged, `range_err`=1.
  - With the macro: writes 16'h13FF.
- **Negative overflow:** 16'h8000, opcode 5'b00101, with the macro.
  - Writes 16'h2C00 and sets `range_err`=1.
- **Full:** `ADDR_WIDTH`=2, four words, no `in_last`.
  - Writes at addresses 0–3, then `done`, `full`=1, `word_count`=4, `in_ready`=0.
- **Reset mid-session:** drive `reset`=0 during a WRITE cycle.
  - Next cycle: `mem_we`=0, state IDLE, all outputs at reset values.
  - A new session after `start` writes at address 0.
- **Handshake holds:** hold `in_valid`=1 across WRITE, and pulse `start` while busy.
  - Each word is consumed exactly once; `start` has no effect; the address sequence is unchanged.
